seg7_countdown_timer: RTL and testbench

//  mm:ss countdown timer with a multiplexed 4-digit seven-segment driver.

---
 rtl/seg7_countdown_timer.sv | 216 +++++++++++++++++++++
 tb/tb_seg7_countdown_timer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_countdown_timer.sv
// mm:ss countdown timer with a multiplexed 4-digit, active-low seven-segment driver.
// Divider square waves are resynchronised into Clk and turned into single-cycle enables.
module seg7_countdown_timer #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN     = 59
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       N_Clk1Hz,
  input  logic       N_Clk381Hz,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Load,
  input  logic [5:0] LoadMin,
  input  logic [5:0] LoadSec,
  output logic [3:0] An,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic       Running,
  output logic       Done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SYNC_STAGES-1:0] r_sync_1hz;
  logic [SYNC_STAGES-1:0] r_sync_scan;
  logic                   r_prev_1hz;
  logic                   r_prev_scan;
  logic                   w_tick1;
  logic                   w_tick_scan;
  logic [3:0]             r_mt, r_mo, r_st, r_so;
  logic [1:0]             r_idx;
  logic                   r_blink;
  logic [3:0]             r_an;
  logic [6:0]             r_seg;
  logic                   r_dp;
  logic [5:0]             w_min_clamp;
  logic [5:0]             w_sec_clamp;
  logic [7:0]             w_min_bcd;
  logic [7:0]             w_sec_bcd;
  logic                   w_is_zero;
  logic                   w_is_one;
  logic                   w_pause_cmd;
  logic                   w_dec;
  logic [3:0]             w_digit;

  function automatic logic [7:0] bin2bcd(input logic [5:0] b);
    logic [5:0] rem;
    logic [3:0] tens;
    rem  = b;
    tens = 4'd0;
    for (int k = 0; k < 5; k++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Synchroniser chains plus one edge-detect flop per tick input
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_sync_1hz  <= '0;
      r_sync_scan <= '0;
      r_prev_1hz  <= 1'b0;
      r_prev_scan <= 1'b0;
    end else begin
      r_sync_1hz  <= {r_sync_1hz[SYNC_STAGES-2:0], N_Clk1Hz};
      r_sync_scan <= {r_sync_scan[SYNC_STAGES-2:0], N_Clk381Hz};
      r_prev_1hz  <= r_sync_1hz[SYNC_STAGES-1];
      r_prev_scan <= r_sync_scan[SYNC_STAGES-1];
    end
  end

  assign w_tick1     = r_sync_1hz[SYNC_STAGES-1] & ~r_prev_1hz;
  assign w_tick_scan = r_sync_scan[SYNC_STAGES-1] & ~r_prev_scan;

  assign w_min_clamp = (LoadMin > 6'(MAX_MIN)) ? 6'(MAX_MIN) : LoadMin;
  assign w_sec_clamp = (LoadSec > 6'd59) ? 6'd59 : LoadSec;
  assign w_min_bcd   = bin2bcd(w_min_clamp);
  assign w_sec_bcd   = bin2bcd(w_sec_clamp);

  assign w_is_zero   = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd0);
  assign w_is_one    = (r_mt == 4'd0) && (r_mo == 4'd0) && (r_st == 4'd0) && (r_so == 4'd1);
  // Higher-priority commands mask Pause; a Pause that wins swallows a coincident tick
  assign w_pause_cmd = Pause & ~Start & ~Load;
  assign w_dec       = (r_state == S_RUN) & w_tick1 & ~w_pause_cmd & ~Load;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_PAUSE: begin
        if (Load)                        w_state_next = S_IDLE;
        else if (Start && !w_is_zero)    w_state_next = S_RUN;
      end
      S_RUN: begin
        if (Load)                        w_state_next = S_IDLE;
        else if (w_dec && w_is_one)      w_state_next = S_DONE;
        else if (w_pause_cmd)            w_state_next = S_PAUSE;
      end
      S_DONE: begin
        if (Load || Start)               w_state_next = S_IDLE;
      end
      default:                           w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    Running = (r_state == S_RUN);
    Done    = (r_state == S_DONE);
  end

  // BCD down-counter with cascaded borrows
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_mt <= 4'd0;
      r_mo <= 4'd0;
      r_st <= 4'd0;
      r_so <= 4'd0;
    end else if (Load) begin
      {r_mt, r_mo} <= w_min_bcd;
      {r_st, r_so} <= w_sec_bcd;
    end else if (w_dec) begin
      if (r_so != 4'd0) begin
        r_so <= r_so - 4'd1;
      end else begin
        r_so <= 4'd9;
        if (r_st != 4'd0) begin
          r_st <= r_st - 4'd1;
        end else begin
          r_st <= 4'd5;
          if (r_mo != 4'd0) begin
            r_mo <= r_mo - 4'd1;
          end else begin
            r_mo <= 4'd9;
            r_mt <= r_mt - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_blink <= 1'b0;
    end else if (w_state_next != S_DONE) begin
      r_blink <= 1'b0;
    end else if (r_state == S_DONE && w_tick1) begin
      r_blink <= ~r_blink;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_idx <= 2'd0;
    end else if (w_tick_scan) begin
      r_idx <= r_idx + 2'd1;
    end
  end

  always_comb begin
    case (r_idx)
      2'd0:    w_digit = r_so;
      2'd1:    w_digit = r_st;
      2'd2:    w_digit = r_mo;
      default: w_digit = r_mt;
    endcase
  end

  // Registered display drive; the decimal point separates mm from ss on digit 2
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_an  <= 4'b1110;
      r_seg <= 7'b1000000;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= r_blink ? 7'b1111111 : seg_decode(w_digit);
      r_dp  <= r_blink | (r_idx != 2'd2);
    end
  end

  assign An  = r_an;
  assign Seg = r_seg;
  assign Dp  = r_dp;

endmodule

// File: tb/tb_seg7_countdown_timer.sv
// Directed bench for seg7_countdown_timer: expectations are queued on stimulus and
// popped against the display / status outputs, sampled on the falling clock edge.
module tb_seg7_countdown_timer;

  localparam int SYNC = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       N_Clk1Hz = 1'b0;
  logic       N_Clk381Hz = 1'b0;
  logic       Start = 1'b0;
  logic       Pause = 1'b0;
  logic       Load = 1'b0;
  logic [5:0] LoadMin = 6'd0;
  logic [5:0] LoadSec = 6'd0;
  logic [3:0] An;
  logic [6:0] Seg;
  logic       Dp;
  logic       Running;
  logic       Done;

  seg7_countdown_timer #(.SYNC_STAGES(SYNC), .MAX_MIN(59)) dut (
    .Clk(Clk), .Reset(Reset), .N_Clk1Hz(N_Clk1Hz), .N_Clk381Hz(N_Clk381Hz),
    .Start(Start), .Pause(Pause), .Load(Load), .LoadMin(LoadMin), .LoadSec(LoadSec),
    .An(An), .Seg(Seg), .Dp(Dp), .Running(Running), .Done(Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   idx_m = 0;
  int   t_m = 0;
  bit   blink_m = 1'b0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int digit_of(input int t, input int i);
    int mins, secs;
    mins = t / 60;
    secs = t % 60;
    case (i)
      0: return secs % 10;
      1: return secs / 10;
      2: return mins % 10;
      default: return mins / 10;
    endcase
  endfunction

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty observed=%0h required=<none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
      end
      $display("[%0t] check %s observed=%0h", $time, e.tag, obs);
    end
  endtask

  task automatic check_status(input string tag, input logic run_e, input logic done_e);
    push_exp({tag, "_running"}, {31'd0, run_e});
    push_exp({tag, "_done"}, {31'd0, done_e});
    pop_cmp({31'd0, Running});
    pop_cmp({31'd0, Done});
  endtask

  // One 381 Hz edge: An must hold for SYNC+1 cycles and change on the SYNC+2nd
  task automatic scan_step();
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    @(negedge Clk) N_Clk381Hz = 1'b1;
    repeat (SYNC + 1) @(negedge Clk);
    ea = ~(4'(1) << idx_m);
    push_exp("an_hold", {28'd0, ea});
    pop_cmp({28'd0, An});
    idx_m = (idx_m + 1) % 4;
    @(negedge Clk);
    ea = ~(4'(1) << idx_m);
    es = blink_m ? 7'b1111111 : seg_of(digit_of(t_m, idx_m));
    ed = blink_m ? 1'b1 : (idx_m != 2);
    push_exp($sformatf("an_idx%0d", idx_m), {28'd0, ea});
    push_exp($sformatf("seg_idx%0d_t%0d", idx_m, t_m), {25'd0, es});
    push_exp($sformatf("dp_idx%0d", idx_m), {31'd0, ed});
    pop_cmp({28'd0, An});
    pop_cmp({25'd0, Seg});
    pop_cmp({31'd0, Dp});
    N_Clk381Hz = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic scan_all();
    repeat (4) scan_step();
  endtask

  task automatic tick1();
    @(negedge Clk) N_Clk1Hz = 1'b1;
    repeat (SYNC + 2) @(negedge Clk);
    N_Clk1Hz = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic do_load(input int m, input int s);
    @(negedge Clk);
    LoadMin = 6'(m);
    LoadSec = 6'(s);
    Load = 1'b1;
    @(negedge Clk) Load = 1'b0;
    t_m = ((m > 59) ? 59 : m) * 60 + ((s > 59) ? 59 : s);
    blink_m = 1'b0;
  endtask

  task automatic do_start();
    @(negedge Clk) Start = 1'b1;
    @(negedge Clk) Start = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge Clk);
    push_exp("rst_an", 32'h0000_000E);
    push_exp("rst_seg", 32'h0000_0040);
    push_exp("rst_dp", 32'd1);
    pop_cmp({28'd0, An});
    pop_cmp({25'd0, Seg});
    pop_cmp({31'd0, Dp});
    check_status("rst", 1'b0, 1'b0);
    @(negedge Clk) Reset = 1'b1;

    // Asynchronous reset while running at 12:34
    do_load(12, 34);
    do_start();
    check_status("run1234", 1'b1, 1'b0);
    scan_step();
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    push_exp("async_an", 32'h0000_000E);
    push_exp("async_seg", 32'h0000_0040);
    pop_cmp({28'd0, An});
    pop_cmp({25'd0, Seg});
    check_status("async", 1'b0, 1'b0);
    @(negedge Clk) Reset = 1'b1;
    idx_m = 0;
    t_m = 0;
    blink_m = 1'b0;
    scan_all();

    // 02:05 counts down through a minute borrow
    do_load(2, 5);
    do_start();
    for (int i = 0; i < 5; i++) begin
      tick1();
      t_m = t_m - 1;
      check_status($sformatf("cnt%0d", i), 1'b1, 1'b0);
    end
    scan_all();
    tick1();
    t_m = t_m - 1;
    check_status("cnt_159", 1'b1, 1'b0);
    scan_all();

    // 00:02 reaches DONE exactly one cycle after the second tick is consumed
    do_load(0, 2);
    do_start();
    tick1();
    t_m = 1;
    @(negedge Clk) N_Clk1Hz = 1'b1;
    repeat (SYNC) @(negedge Clk);
    check_status("pre_done", 1'b1, 1'b0);
    @(negedge Clk);
    t_m = 0;
    check_status("done", 1'b0, 1'b1);
    N_Clk1Hz = 1'b0;
    repeat (3) @(negedge Clk);
    scan_all();
    tick1();
    blink_m = 1'b1;
    scan_all();
    tick1();
    blink_m = 1'b0;
    scan_step();
    do_start();
    check_status("done_ack", 1'b0, 1'b0);
    scan_all();

    // Pause coinciding with a tick at 00:10 discards that tick
    do_load(0, 10);
    do_start();
    @(negedge Clk) N_Clk1Hz = 1'b1;
    repeat (SYNC) @(negedge Clk);
    Pause = 1'b1;
    @(negedge Clk) Pause = 1'b0;
    check_status("paused", 1'b0, 1'b0);
    N_Clk1Hz = 1'b0;
    repeat (3) @(negedge Clk);
    tick1();
    scan_all();
    do_start();
    check_status("resumed", 1'b1, 1'b0);
    tick1();
    t_m = 9;
    scan_all();

    // Clamp on load, and Start refused at 00:00
    do_load(63, 63);
    check_status("clamp", 1'b0, 1'b0);
    scan_all();
    do_load(0, 0);
    do_start();
    check_status("start_zero", 1'b0, 1'b0);

    // Eight consecutive scan edges wrap the anode sequence twice
    do_load(47, 38);
    repeat (8) scan_step();

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_leftover observed=%0d required=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
